// File: rtl/counter8_pkg.sv
// counter8_pkg: shared definitions for the counter8 command sequencer.
//   DATA_W      - counter8 data width
//   OP_*        - command opcodes (5..7 are illegal)
//   state_t     - sequencer FSM states
//   op_is_count - true for INC/DEC
package counter8_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_READ = 3'd0;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd2;
  localparam logic [OP_W-1:0] OP_INC  = 3'd3;
  localparam logic [OP_W-1:0] OP_DEC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_RUN,
    ST_STOP,
    ST_SETTLE,
    ST_REPORT,
    ST_ERROR
  } state_t;

  function automatic logic op_is_count(input logic [OP_W-1:0] op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/counter8_seq_if.sv
// counter8_seq_if: command / completion channel between a requester and
// counter8_seq.
//   CMD_VALID/CMD_READY  - command handshake
//   CMD_OP/DATA/RUN      - opcode, load value, count length
//   HOLD_REQ             - pause request during a count run
//   DONE_VALID/DONE_DATA - completion pulse and captured counter value
//   ERR                  - illegal-opcode pulse
//   BUSY                 - sequencer not idle
// master = requester side, slave = sequencer side.
interface counter8_seq_if #(
  parameter int RUN_W = 8
);
  import counter8_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [OP_W-1:0]   CMD_OP;
  logic [DATA_W-1:0] CMD_DATA;
  logic [RUN_W-1:0]  CMD_RUN;
  logic              HOLD_REQ;
  logic              DONE_VALID;
  logic [DATA_W-1:0] DONE_DATA;
  logic              ERR;
  logic              BUSY;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DATA, CMD_RUN, HOLD_REQ,
    input  CMD_READY, DONE_VALID, DONE_DATA, ERR, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DATA, CMD_RUN, HOLD_REQ,
    output CMD_READY, DONE_VALID, DONE_DATA, ERR, BUSY
  );

endinterface

// File: rtl/counter8_seq.sv
// counter8_seq: takes single commands (READ, CLR, LOAD, INC N, DEC N) and
// drives the counter8 strobes with one-cycle pulses, then reports DOUT.
//   CLK, RESETn         - clock, synchronous active-low reset
//   cmd                 - command/completion channel (slave side)
//   CLR, LOAD           - counter8 clear / load strobes
//   INC_START, INC_END  - counter8 up-count window strobes
//   DEC_START, DEC_END  - counter8 down-count window strobes
//   HOLD                - counter8 hold (only during RUN)
//   MODE_SEL            - constant 1
//   DIN                 - counter8 load data (holds last loaded value)
//   DOUT                - counter8 output
//
// state  | meaning
// IDLE   | ready for a command
// STROBE | one-cycle CLR / LOAD / *_START pulse
// RUN    | counting, N non-held cycles
// STOP   | one-cycle *_END pulse
// SETTLE | wait for DOUT to update
// REPORT | DONE_VALID pulse with captured DOUT
// ERROR  | ERR pulse for an illegal opcode
module counter8_seq
  import counter8_pkg::*;
#(
  parameter int RUN_W = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  counter8_seq_if.slave     cmd,
  output logic              CLR,
  output logic              LOAD,
  output logic              INC_START,
  output logic              INC_END,
  output logic              DEC_START,
  output logic              DEC_END,
  output logic              HOLD,
  output logic              MODE_SEL,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DOUT
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [RUN_W-1:0]  cnt_q, cnt_d;

  // Outputs are registered from their next-state values so every strobe
  // lines up with the state it belongs to.
  logic              clr_d, load_d, inc_start_d, inc_end_d, dec_start_d, dec_end_d;
  logic              hold_d, err_d, done_valid_d, ready_d, busy_d;
  logic [DATA_W-1:0] din_d, done_data_d;

  assign MODE_SEL = 1'b1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    clr_d        = 1'b0;
    load_d       = 1'b0;
    inc_start_d  = 1'b0;
    inc_end_d    = 1'b0;
    dec_start_d  = 1'b0;
    dec_end_d    = 1'b0;
    hold_d       = 1'b0;
    err_d        = 1'b0;
    done_valid_d = 1'b0;
    done_data_d  = cmd.DONE_DATA;
    din_d        = DIN;

    case (state_q)
      ST_IDLE: begin
        if (cmd.CMD_VALID) begin
          op_d  = cmd.CMD_OP;
          run_d = cmd.CMD_RUN;
          case (cmd.CMD_OP)
            OP_READ: state_d = ST_SETTLE;
            OP_CLR: begin
              state_d = ST_STROBE;
              clr_d   = 1'b1;
            end
            OP_LOAD: begin
              state_d = ST_STROBE;
              load_d  = 1'b1;
              din_d   = cmd.CMD_DATA;
            end
            OP_INC: begin
              state_d     = ST_STROBE;
              inc_start_d = 1'b1;
            end
            OP_DEC: begin
              state_d     = ST_STROBE;
              dec_start_d = 1'b1;
            end
            default: begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_STROBE: begin
        if (op_is_count(op_q)) begin
          if (run_q == '0) begin
            state_d   = ST_STOP;
            inc_end_d = (op_q == OP_INC);
            dec_end_d = (op_q == OP_DEC);
          end else begin
            state_d = ST_RUN;
            cnt_d   = run_q - 1'b1;
          end
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_RUN: begin
        if (cmd.HOLD_REQ) begin
          hold_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = ST_STOP;
          inc_end_d = (op_q == OP_INC);
          dec_end_d = (op_q == OP_DEC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_STOP: state_d = ST_SETTLE;

      ST_SETTLE: begin
        state_d      = ST_REPORT;
        done_valid_d = 1'b1;
        done_data_d  = DOUT;
      end

      ST_REPORT: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_READ;
      run_q          <= '0;
      cnt_q          <= '0;
      CLR            <= 1'b0;
      LOAD           <= 1'b0;
      INC_START      <= 1'b0;
      INC_END        <= 1'b0;
      DEC_START      <= 1'b0;
      DEC_END        <= 1'b0;
      HOLD           <= 1'b0;
      DIN            <= '0;
      cmd.CMD_READY  <= 1'b1;
      cmd.BUSY       <= 1'b0;
      cmd.ERR        <= 1'b0;
      cmd.DONE_VALID <= 1'b0;
      cmd.DONE_DATA  <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      run_q          <= run_d;
      cnt_q          <= cnt_d;
      CLR            <= clr_d;
      LOAD           <= load_d;
      INC_START      <= inc_start_d;
      INC_END        <= inc_end_d;
      DEC_START      <= dec_start_d;
      DEC_END        <= dec_end_d;
      HOLD           <= hold_d;
      DIN            <= din_d;
      cmd.CMD_READY  <= ready_d;
      cmd.BUSY       <= busy_d;
      cmd.ERR        <= err_d;
      cmd.DONE_VALID <= done_valid_d;
      cmd.DONE_DATA  <= done_data_d;
    end
  end

endmodule

// File: tb/tb_counter8_seq.sv
// tb_counter8_seq: directed bench for counter8_seq with a behavioural
// counter8 model attached to the strobes.
module tb_counter8_seq;
  import counter8_pkg::*;

  logic       CLK;
  logic       RESETn;
  logic       CLR, LOAD, INC_START, INC_END, DEC_START, DEC_END, HOLD, MODE_SEL;
  logic [7:0] DIN;
  logic [7:0] DOUT;

  counter8_seq_if #(.RUN_W(8)) ifc ();

  counter8_seq #(.RUN_W(8)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .cmd       (ifc),
    .CLR       (CLR),
    .LOAD      (LOAD),
    .INC_START (INC_START),
    .INC_END   (INC_END),
    .DEC_START (DEC_START),
    .DEC_END   (DEC_END),
    .HOLD      (HOLD),
    .MODE_SEL  (MODE_SEL),
    .DIN       (DIN),
    .DOUT      (DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // counter8 model: steps on edges strictly between sampling START and END.
  logic c8_run, c8_up;
  always @(posedge CLK) begin
    if (!RESETn) begin
      DOUT   <= 8'h00;
      c8_run <= 1'b0;
      c8_up  <= 1'b0;
    end else if (CLR) begin
      DOUT <= 8'h00;
    end else if (LOAD) begin
      DOUT <= DIN;
    end else if (INC_START) begin
      c8_run <= 1'b1;
      c8_up  <= 1'b1;
    end else if (DEC_START) begin
      c8_run <= 1'b1;
      c8_up  <= 1'b0;
    end else if (INC_END || DEC_END) begin
      c8_run <= 1'b0;
    end else if (c8_run && !HOLD) begin
      DOUT <= c8_up ? DOUT + 8'd1 : DOUT - 8'd1;
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-command observations, cycle k = k-th cycle after the accept edge.
  int n_clr, n_load, n_start, n_end, n_hold, n_err, n_done;
  int start_k, end_k, lat, ready_k, dval;

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                         input logic [7:0] run, input int keep,
                         input int hold_at, input int hold_len);
    int k;
    n_clr = 0; n_load = 0; n_start = 0; n_end = 0; n_hold = 0;
    n_err = 0; n_done = 0; start_k = -1; end_k = -1; lat = -1;
    ready_k = -1; dval = -1;
    @(negedge CLK);
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP    = op;
    ifc.CMD_DATA  = data;
    ifc.CMD_RUN   = run;
    ifc.HOLD_REQ  = 1'b0;
    @(posedge CLK);
    k = 0;
    while (k < 300) begin
      @(negedge CLK);
      k++;
      if (k >= keep) ifc.CMD_VALID = 1'b0;
      if (CLR) n_clr++;
      if (LOAD) n_load++;
      if (INC_START || DEC_START) begin n_start++; start_k = k; end
      if (INC_END || DEC_END) begin n_end++; end_k = k; end
      if (HOLD) n_hold++;
      if (ifc.ERR) n_err++;
      if (ifc.DONE_VALID) begin n_done++; lat = k; dval = int'(ifc.DONE_DATA); end
      if (ifc.CMD_READY) begin ready_k = k; break; end
      ifc.HOLD_REQ = (k >= hold_at) && (k < hold_at + hold_len);
    end
    ifc.CMD_VALID = 1'b0;
    ifc.HOLD_REQ  = 1'b0;
    check_val("ready_returns", int'(ready_k > 0), 1);
  endtask

  initial begin
    RESETn        = 1'b0;
    ifc.CMD_VALID = 1'b0;
    ifc.CMD_OP    = 3'd0;
    ifc.CMD_DATA  = 8'h00;
    ifc.CMD_RUN   = 8'h00;
    ifc.HOLD_REQ  = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_ready", int'(ifc.CMD_READY), 1);
    check_val("rst_busy", int'(ifc.BUSY), 0);
    check_val("rst_mode_sel", int'(MODE_SEL), 1);
    check_val("rst_strobes", int'({CLR, LOAD, INC_START, INC_END, DEC_START, DEC_END, HOLD}), 0);
    check_val("rst_done_err", int'({ifc.DONE_VALID, ifc.ERR}), 0);
    check_val("rst_din", int'(DIN), 0);
    RESETn = 1'b1;

    // CLR, with CMD_VALID left high across the busy cycles
    run_cmd(OP_CLR, 8'h00, 8'd0, 3, 999, 0);
    check_val("clr_pulses", n_clr, 1);
    check_val("clr_latency", lat, 3);
    check_val("clr_data", dval, 8'h00);
    check_val("clr_ready_k", ready_k, 4);

    run_cmd(OP_LOAD, 8'h0A, 8'd0, 1, 999, 0);
    check_val("load_pulses", n_load, 1);
    check_val("load_data", dval, 8'h0A);
    check_val("load_din", int'(DIN), 8'h0A);

    run_cmd(OP_INC, 8'h00, 8'd5, 1, 999, 0);
    check_val("inc5_data", dval, 8'h0F);
    check_val("inc5_run_gap", end_k - start_k - 1, 5);
    check_val("inc5_latency", lat, 9);

    run_cmd(OP_LOAD, 8'h02, 8'd0, 1, 999, 0);
    run_cmd(OP_DEC, 8'h00, 8'd4, 1, 999, 0);
    check_val("dec4_wrap_data", dval, 8'hFE);
    check_val("dec4_latency", lat, 8);

    run_cmd(OP_LOAD, 8'hFE, 8'd0, 1, 999, 0);
    run_cmd(OP_INC, 8'h00, 8'd3, 1, 999, 0);
    check_val("inc3_wrap_data", dval, 8'h01);

    run_cmd(OP_LOAD, 8'h0A, 8'd0, 1, 999, 0);
    run_cmd(OP_INC, 8'h00, 8'd10, 1, 4, 2);
    check_val("hold_cycles", n_hold, 2);
    check_val("hold_data", dval, 8'h14);
    check_val("hold_latency", lat, 16);

    run_cmd(3'd6, 8'h55, 8'd3, 1, 999, 0);
    check_val("err_pulses", n_err, 1);
    check_val("err_strobes", n_clr + n_load + n_start + n_end, 0);
    check_val("err_no_done", n_done, 0);
    check_val("err_ready_k", ready_k, 2);

    run_cmd(OP_INC, 8'h00, 8'd0, 1, 999, 0);
    check_val("inc0_gap", end_k - start_k, 1);
    check_val("inc0_data", dval, 8'h14);
    check_val("inc0_latency", lat, 4);
    check_val("din_held", int'(DIN), 8'h0A);

    run_cmd(OP_READ, 8'h00, 8'd0, 1, 999, 0);
    check_val("read_data", dval, 8'h14);
    check_val("read_latency", lat, 2);

    // reset in the middle of a long run
    @(negedge CLK);
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP    = OP_INC;
    ifc.CMD_RUN   = 8'd20;
    @(posedge CLK);
    @(negedge CLK);
    ifc.CMD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check_val("midrun_busy", int'(ifc.BUSY), 1);
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    check_val("midrun_rst_strobes", int'({CLR, LOAD, INC_START, INC_END, DEC_START, DEC_END, HOLD}), 0);
    check_val("midrun_rst_ready", int'(ifc.CMD_READY), 1);
    check_val("midrun_rst_busy", int'(ifc.BUSY), 0);
    check_val("midrun_rst_din", int'(DIN), 0);
    @(negedge CLK);
    RESETn = 1'b1;

    run_cmd(OP_READ, 8'h00, 8'd0, 1, 999, 0);
    check_val("post_rst_read", dval, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/counter8_seq.md
# counter8_seq

Command sequencer for the `counter8` datapath. It accepts single commands (read, clear, load, count up N, count down N) over a valid/ready handshake. It drives the `counter8` control strobes with correct one-cycle pulse timing and returns the resulting `DOUT` value with a done pulse. It sits between a host/CPU-side requester and one `counter8` instance, replacing hand-driven strobes.

## Interface
Parameters:
- `RUN_W`, 8: width of the run-length field and internal run counter.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESETn`  in  1  synchronous, active-low reset. The same signal drives `counter8`.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  controller can accept; high only in IDLE.
- `CMD_OP`  in  3  opcode: 0 READ, 1 CLR, 2 LOAD, 3 INC, 4 DEC; 5–7 illegal.
- `CMD_DATA`  in  8  load value (LOAD only).
- `CMD_RUN`  in  RUN_W  count steps N (INC/DEC only).
- `HOLD_REQ`  in  1  pause request during a count run.
- `DONE_VALID`  out  1  one-cycle pulse; `DONE_DATA` valid.
- `DONE_DATA`  out  8  `DOUT` captured at completion.
- `ERR`  out  1  one-cycle pulse on illegal opcode.
- `BUSY`  out  1  high whenever not IDLE.
- `CLR`, `LOAD`, `INC_START`, `INC_END`, `DEC_START`, `DEC_END`  out  1 each  `counter8` strobes.
- `HOLD`  out  1  `counter8` hold.
- `MODE_SEL`  out  1  constant 1.
- `DIN`  out  8  `counter8` load data.
- `DOUT`  in  8  `counter8` output.

## Operation
- All outputs are registered.
- Reset values: `CMD_READY`=1; `MODE_SEL`=1; every other output 0. State returns to IDLE.
- FSM states:
  - **IDLE**: `CMD_READY`=1. On `CMD_VALID`, latch op, data and run, then:
    - READ → SETTLE
    - CLR, LOAD, INC, DEC → STROBE
    - illegal → ERROR
  - **STROBE**: one cycle.
    - CLR: `CLR`=1.
    - LOAD: `LOAD`=1, with `DIN`=latched data.
    - INC/DEC: `INC_START`/`DEC_START`=1.
    - Next state: RUN for INC/DEC with N>0; STOP for INC/DEC with N=0; SETTLE for CLR/LOAD.
  - **RUN**: all strobes low. The run counter loads N−1 on entry and decrements each cycle with `HOLD_REQ`=0. Exit to STOP after the cycle in which it reads 0, giving exactly N non-held cycles.
  - **STOP**: one cycle of `INC_END`/`DEC_END`=1 → SETTLE.
  - **SETTLE**: one idle cycle for `DOUT` to update → REPORT.
  - **REPORT**: `DONE_DATA`←`DOUT`, `DONE_VALID`=1 for one cycle → IDLE.
  - **ERROR**: `ERR`=1 for one cycle; no strobes → IDLE.
- `counter8` steps once per rising edge between sampling START and sampling END, exclusive. The result is therefore start ± N mod 256; wrap-around is normal and not flagged.
- `HOLD_REQ`:
  - In RUN only, `HOLD` follows `HOLD_REQ` registered, and the run counter freezes.
  - In every other state `HOLD`=0 and `HOLD_REQ` is ignored.
  - `HOLD_REQ` held indefinitely stalls RUN indefinitely.
- Commands presented while `CMD_READY`=0 are not taken. The requester keeps `CMD_VALID`/payload stable until accepted.
- `DIN` holds the last loaded value outside LOAD.

## Timing
- Let E0 be the edge at which `CMD_VALID`&`CMD_READY` are sampled high.
- CLR/LOAD:
  - Strobe high E0→E1.
  - SETTLE E1→E2.
  - `DONE_VALID` high E2→E3.
  - `CMD_READY` high from E3.
  - Latency 3 cycles.
- READ: `DONE_VALID` high E1→E2.
- INC/DEC N, no hold:
  - START high E0→E1.
  - RUN E1→E1+N.
  - END high E1+N→E2+N.
  - `DONE_VALID` high E3+N→E4+N.
  - Latency N+4.
- Each held cycle adds 1 to the INC/DEC latency.
- Illegal opcode: `ERR` high E0→E1; `CMD_READY` high from E1.
- `RESETn` low at any edge, including mid-RUN, returns all outputs to reset values at that edge. No END strobe is issued; `counter8` is reset by the same signal.

## Structure
- Shared package `counter8_pkg`:
  - opcode constants (`OP_READ`..`OP_DEC`)
  - FSM state enum
  - data width 8
- Single module; no sub-module needed. The run counter is inline.
- `counter8_sys` wraps `counter8_seq` plus `counter8` for system use and test.

## Test plan
- Reset, then CLR → exactly one `CLR` pulse; `DONE_VALID` at E0+2 with `DONE_DATA`=0x00; `CMD_READY` back at E0+3.
- LOAD 0x0A, then INC N=5 → `DONE_DATA`=0x0F; START-to-END spacing exactly 5 cycles.
- LOAD 0x02, DEC N=4 → `DONE_DATA`=0xFE (wrap). LOAD 0xFE, INC N=3 → 0x01.
- LOAD 0x0A, INC N=10, `HOLD_REQ` high for 2 cycles mid-run → `HOLD` high 2 cycles; `DONE_DATA`=0x14; latency 16.
- OP=6 → `ERR` pulse only, no strobes, no `DONE_VALID`. INC N=0 → START then END on consecutive cycles; `DONE_DATA` unchanged.
- `RESETn` low during RUN → all strobes 0, `CMD_READY`=1 next cycle. `CMD_VALID` held while BUSY → accepted only once.
